// File: rtl/pwm_timer_pkg.sv
// Shared constants for the multi-channel PWM timer: operating modes and
// count direction.
package pwm_timer_pkg;

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_TIMER  = 2'b01;
  localparam logic [1:0] MODE_EDGE   = 2'b10;
  localparam logic [1:0] MODE_CENTER = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM compare channel: shadowed compare value, comparison against the
// shared counter, polarity inversion and a registered output.
module pwm_compare_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             idle,
  input  logic [WIDTH-1:0] cmp_in,
  input  logic [WIDTH-1:0] count,
  input  logic             polarity,
  output logic             pwm
);

  logic [WIDTH-1:0] cmp_sh_q, cmp_sh_d;
  logic             pwm_q, pwm_d;

  // Compare against the shadow, never the live input, so mid-period writes
  // cannot create runt pulses.
  always_comb begin
    cmp_sh_d = load ? cmp_in : cmp_sh_q;
    pwm_d    = idle ? polarity : ((count < cmp_sh_q) ^ polarity);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_sh_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cmp_sh_q <= cmp_sh_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_timer_multi.sv
// Multi-channel timer/PWM: shared prescaler, period counter (up or up/down),
// shadowed period top and CH compare channels with a one-cycle update interrupt.
module pwm_timer_multi
  import pwm_timer_pkg::*;
#(
  parameter int CH         = 4,
  parameter int WIDTH      = 16,
  parameter int PRES_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic [PRES_WIDTH-1:0] prescaler,
  input  logic [WIDTH-1:0]      max_count,
  input  logic [CH*WIDTH-1:0]   compare,
  input  logic [CH-1:0]         polarity,
  output logic [CH-1:0]         pwm,
  output logic                  timer_int,
  output logic [WIDTH-1:0]      count
);

  logic [1:0]            mode_q;
  logic [PRES_WIDTH-1:0] pres_q, pres_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      max_sh_q, max_sh_d;
  dir_e                  dir_q, dir_d;
  logic                  int_q, int_d;
  logic                  mode_change, tick, update, load, idle;

  always_comb begin
    mode_change = (mode != mode_q);
    tick        = (pres_q == prescaler);
    pres_d      = pres_q;
    count_d     = count_q;
    dir_d       = dir_q;
    update      = 1'b0;
    if (mode_change || mode == MODE_STOP) begin
      pres_d  = '0;
      count_d = '0;
      dir_d   = DIR_UP;
    end else begin
      pres_d = tick ? '0 : pres_q + 1'b1;
      if (tick) begin
        if (mode == MODE_CENTER) begin
          // A zero top keeps the counter parked at 0 and going up.
          if (dir_q == DIR_UP) begin
            if (max_sh_q == '0) begin
              count_d = '0;
              update  = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
              if (count_d == max_sh_q) dir_d = DIR_DOWN;
            end
          end else begin
            count_d = count_q - 1'b1;
            if (count_d == '0) begin
              dir_d  = DIR_UP;
              update = 1'b1;
            end
          end
        end else if (count_q == max_sh_q) begin
          count_d = '0;
          update  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
    load     = mode_change || (mode == MODE_STOP) || update;
    idle     = mode_change || (mode == MODE_STOP) || (mode == MODE_TIMER);
    max_sh_d = load ? max_count : max_sh_q;
    int_d    = update;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_STOP;
      pres_q   <= '0;
      count_q  <= '0;
      max_sh_q <= '0;
      dir_q    <= DIR_UP;
      int_q    <= 1'b0;
    end else begin
      mode_q   <= mode;
      pres_q   <= pres_d;
      count_q  <= count_d;
      max_sh_q <= max_sh_d;
      dir_q    <= dir_d;
      int_q    <= int_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pwm_compare_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .idle     (idle),
      .cmp_in   (compare[k*WIDTH +: WIDTH]),
      .count    (count_q),
      .polarity (polarity[k]),
      .pwm      (pwm[k])
    );
  end

  assign count     = count_q;
  assign timer_int = int_q;

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Bench for pwm_timer_multi: directed scenarios plus random traffic, checked
// every cycle against a period/phase model of the timer.
module tb_pwm_timer_multi;
  import pwm_timer_pkg::*;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        mode = MODE_STOP;
  logic [PW-1:0]     prescaler = '0;
  logic [W-1:0]      max_count = '0;
  logic [CH*W-1:0]   compare = '0;
  logic [CH-1:0]     polarity = '0;
  logic [CH-1:0]     pwm;
  logic              timer_int;
  logic [W-1:0]      count;

  int checks = 0;
  int failures = 0;

  // Reference model: position inside the current period, not a direction bit.
  logic [1:0]    m_mode_prev;
  logic [PW-1:0] m_pres;
  int            m_phase;
  int            m_max;
  int            m_cmp[CH];
  logic [CH-1:0] m_pwm;
  logic          m_int;

  int win_hi[CH];
  int win_int;

  pwm_timer_multi #(.CH(CH), .WIDTH(W), .PRES_WIDTH(PW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .prescaler (prescaler),
    .max_count (max_count),
    .compare   (compare),
    .polarity  (polarity),
    .pwm       (pwm),
    .timer_int (timer_int),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    if (m_mode_prev == MODE_CENTER && m_phase > m_max) return 2 * m_max - m_phase;
    return m_phase;
  endfunction

  task automatic load_shadows();
    m_max = int'(max_count);
    for (int k = 0; k < CH; k++) m_cmp[k] = int'(compare[k*W +: W]);
  endtask

  task automatic model_reset();
    m_mode_prev = MODE_STOP;
    m_pres = '0;
    m_phase = 0;
    m_max = 0;
    for (int k = 0; k < CH; k++) m_cmp[k] = 0;
    m_pwm = '0;
    m_int = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int  old_cnt;
    int  period;
    bit  tick;
    old_cnt = model_count();
    m_int = 1'b0;
    if (mode != m_mode_prev || mode == MODE_STOP) begin
      m_pres = '0;
      m_phase = 0;
      load_shadows();
      m_pwm = polarity;
    end else begin
      for (int k = 0; k < CH; k++)
        m_pwm[k] = (mode == MODE_TIMER) ? polarity[k] : ((old_cnt < m_cmp[k]) ^ polarity[k]);
      tick = (m_pres == prescaler);
      m_pres = tick ? '0 : m_pres + 1'b1;
      if (tick) begin
        m_phase++;
        period = (mode == MODE_CENTER) ? 2 * m_max : m_max + 1;
        if (period < 1) period = 1;
        if (m_phase >= period) begin
          m_phase = 0;
          m_int = 1'b1;
          load_shadows();
        end
      end
    end
    m_mode_prev = mode;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("count", 64'(count), 64'(model_count()));
    check("pwm", 64'(pwm), 64'(m_pwm));
    check("timer_int", 64'(timer_int), 64'(m_int));
  endtask

  task automatic run_window(input int n);
    for (int k = 0; k < CH; k++) win_hi[k] = 0;
    win_int = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      for (int k = 0; k < CH; k++) win_hi[k] += int'(pwm[k]);
      win_int += int'(timer_int);
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before the next edge.
  task automatic async_reset(input logic [CH-1:0] pol_exp_after);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_count", 64'(count), 64'd0);
    check("rst_async_pwm", 64'(pwm), 64'd0);
    check("rst_async_int", 64'(timer_int), 64'd0);
    #1;
    reset_n = 1'b1;
    cycle();
    check("pwm_after_reset", 64'(pwm), 64'(pol_exp_after));
  endtask

  initial begin
    int t_first, t_second, t_idx, nmode;
    model_reset();
    max_count = 16'd9;
    compare = {16'd5, 16'd10, 16'd3, 16'd0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_pwm", 64'(pwm), 64'd0);
    check("reset_int", 64'(timer_int), 64'd0);
    reset_n = 1'b1;
    repeat (3) cycle();

    // Edge-aligned: duties 0, 3, 10 (over top) and 5 of 10.
    mode = MODE_EDGE;
    cycle();
    repeat (12) cycle();
    run_window(30);
    check("edge_hi_ch0", 64'(win_hi[0]), 64'd0);
    check("edge_hi_ch1", 64'(win_hi[1]), 64'd9);
    check("edge_hi_ch2", 64'(win_hi[2]), 64'd30);
    check("edge_hi_ch3", 64'(win_hi[3]), 64'd15);
    check("edge_int", 64'(win_int), 64'd3);

    // Shadowed compare change mid-period.
    for (int i = 0; i < 40 && count != 16'd4; i++) cycle();
    check("wait_cnt4", 64'(count), 64'd4);
    compare[1*W +: W] = 16'd7;
    for (int i = 0; i < 40 && timer_int != 1'b1; i++) cycle();
    check("wait_wrap", 64'(timer_int), 64'd1);
    run_window(10);
    check("shadow_hi_ch1", 64'(win_hi[1]), 64'd7);

    // Edge -> timer at count 5, with new prescaler and top.
    for (int i = 0; i < 40 && count != 16'd5; i++) cycle();
    check("wait_cnt5", 64'(count), 64'd5);
    mode = MODE_TIMER;
    prescaler = 16'd4;
    max_count = 16'd3;
    cycle();
    check("switch_count", 64'(count), 64'd0);
    check("switch_int", 64'(timer_int), 64'd0);
    check("switch_pwm", 64'(pwm), 64'(polarity));
    t_first = -1;
    t_second = -1;
    t_idx = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      t_idx++;
      if (timer_int) begin
        if (t_first < 0) t_first = t_idx;
        else if (t_second < 0) t_second = t_idx;
      end
    end
    check("timer_int_interval", 64'(t_second - t_first), 64'd20);

    // Center-aligned, top 8, ch0 compare 2.
    mode = MODE_CENTER;
    prescaler = 16'd0;
    max_count = 16'd8;
    compare = {16'd5, 16'd10, 16'd3, 16'd2};
    cycle();
    repeat (20) cycle();
    run_window(32);
    check("center_hi_ch0", 64'(win_hi[0]), 64'd6);
    check("center_int", 64'(win_int), 64'd2);

    // Reset mid-period with all channels inverted.
    polarity = 4'hf;
    repeat (3) cycle();
    mode = MODE_STOP;
    async_reset(4'hf);
    repeat (2) cycle();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        nmode = (int'(mode) + int'($urandom_range(1, 3))) % 4;
        mode = 2'(nmode);
        prescaler = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) max_count = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0)
        compare[$urandom_range(0, CH-1)*W +: W] = 16'($urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) polarity = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        mode = MODE_STOP;
        async_reset(polarity);
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
